instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader that writes instruction memory over a byte stream. It receives a length header and a little-endian word payload from a byte-wide valid/ready source. It assembles 32-bit words and drives the instruction memory write port. It holds the CPU in reset until the image is fully written.

## Interface
- `ADDR_WIDTH`, default 32: width of the instruction memory write address.
- `BASE_ADDR`, default 32'hBFC0_0000: byte address of the first loaded word.
- `MAX_WORDS`, default 1024: largest accepted word count.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-low.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle. A byte transfers when `rx_valid && rx_ready`.
- `we` out 1: instruction memory write enable, one-cycle pulse per word.
- `waddr` out ADDR_WIDTH: byte address of the write.
- `wdata` out 32: word to write.
- `cpu_hold` out 1: active-high hold; drives the CPU's reset while loading.
- `done` out 1: image loaded successfully (sticky until reset).
- `error` out 1: load aborted (sticky until reset).

## Operation
- States: LEN_LO, LEN_HI, PAYLOAD, CSUM (only if configured), DONE, ERROR.
- Reset is sampled at the edge with `rst`=0. It applies regardless of state. Outputs under reset and after it:
  - State goes to LEN_LO.
  - `rx_ready`=0 while `rst`=0; `we`=0; `waddr`=BASE_ADDR; `wdata`=0.
  - `cpu_hold`=1, `done`=0, `error`=0.
  - Byte counter, word counter and any partial word are cleared.
- `rx_ready` is 1 in LEN_LO, LEN_HI, PAYLOAD and CSUM. It is 0 in DONE, ERROR and during reset.
- LEN_LO: an accepted byte gives N[7:0]. Go to LEN_HI.
- LEN_HI: an accepted byte gives N[15:8].
  - N > MAX_WORDS: go to ERROR.
  - N = 0: go to CSUM if configured, else DONE.
  - Otherwise: go to PAYLOAD.
- PAYLOAD: bytes are little-endian. Byte 0 lands in bits [7:0] and byte 3 in bits [31:24].
  - After the 4th byte of word i is accepted, the next cycle has `we`=1, `wdata`=word, `waddr`=BASE_ADDR + 4*i. Addresses are computed modulo 2^ADDR_WIDTH.
  - `rx_ready` stays 1 during the write cycle. Back-to-back bytes never stall.
  - After word N-1 is accepted: go to CSUM if configured, else DONE.
- `rx_valid`=0 cycles simply pause progress; no timeout.
- DONE: `cpu_hold`=0, `done`=1; all further bytes are ignored.
- ERROR: `cpu_hold`=1, `error`=1, `rx_ready`=0. Only reset exits ERROR.
- `done` and `error` are never both 1.
- Reset mid-payload: the partial word is discarded, no `we` pulse occurs, and the next byte is taken as N[7:0].

## Timing
- Last payload byte accepted at cycle k: `we` pulses at k+1.
- Without CSUM: `done`=1 and `cpu_hold`=0 from k+2. The final write always lands one cycle before the CPU is released.
- CSUM byte accepted at cycle c: DONE or ERROR is visible from c+1.
- Oversize N accepted at cycle h: `error`=1 from h+1.
- All outputs are registered; none is combinational from `rx_valid` or `rx_data`, except `rx_ready`, which is decoded from state and `rst`.

## Configuration
- `LOADER_CSUM_EN` defined: the CSUM state exists.
  - After the payload, or directly after LEN_HI when N=0, one byte is accepted and compared with the XOR of all payload bytes (0 when N=0).
  - Equal: go to DONE. Different: go to ERROR. Words already written are not undone.
- `LOADER_CSUM_EN` undefined: there is no CSUM state and the stream ends after the last payload byte.

## Test plan
- N=2, payload 13 00 00 00 93 05 50 00, CSUM off: two writes, BASE_ADDR←32'h0000_0013 and BASE_ADDR+4←32'h0050_0593; `done`=1 and `cpu_hold`=0 two cycles after the last byte.
- N=0, header 00 00, CSUM off: no `we` pulse; `done`=1 one cycle after the second header byte.
- N=MAX_WORDS+1: `error`=1 and `rx_ready`=0 from the next cycle; `cpu_hold` stays 1; no write ever occurs.
- CSUM on, N=1, payload 01 02 04 08: CSUM byte 0F gives `done`=1; CSUM byte 0E gives `error`=1; the single write of 32'h0804_0201 occurs in both cases.
- `rst`=0 after 2 bytes of word 1: no second write; after release, header 01 00 plus 4 bytes writes BASE_ADDR only and sets `done`.
- `rx_valid` toggled randomly at 50% duty during a 4-word load: write data and addresses identical to the gap-free run; `we` count equals 4.

Source files
------------

// File: rtl/instr_loader.sv
// Boot-time loader: length header + little-endian word payload over a byte stream into instruction memory.
// Optional trailing XOR checksum byte enabled by defining LOADER_CSUM_EN.
module instr_loader #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'hBFC0_0000,
  parameter int          MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    PAYLOAD,
`ifdef LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

`ifdef LOADER_CSUM_EN
  localparam state_t END_STATE = CSUM;
`else
  localparam state_t END_STATE = DONE;
`endif

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t      state;
  state_t      next_state;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic        fin_pend;
  logic        take;
  logic        last_byte;
  logic [15:0] hdr_n;
`ifdef LOADER_CSUM_EN
  logic [7:0]  csum;
`endif

  assign take      = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, len[7:0]};
  assign last_byte = (byte_cnt == 2'd3) && ((word_cnt + 16'd1) == len);

  always_comb begin
    rx_ready = 1'b0;
    if (rst) begin
      case (state)
        LEN_LO, LEN_HI, PAYLOAD: rx_ready = 1'b1;
`ifdef LOADER_CSUM_EN
        CSUM:                    rx_ready = 1'b1;
`endif
        default:                 rx_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= LEN_LO;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LEN_LO:
        if (take) next_state = LEN_HI;
      LEN_HI:
        if (take) begin
          if ({16'd0, hdr_n} > 32'(MAX_WORDS))
            next_state = ERROR;
          else if (hdr_n == 16'd0)
            next_state = END_STATE;
          else
            next_state = PAYLOAD;
        end
      PAYLOAD:
        if (take && last_byte) next_state = END_STATE;
`ifdef LOADER_CSUM_EN
      CSUM:
        if (take) next_state = (rx_data == csum) ? DONE : ERROR;
`endif
      default:
        next_state = state;
    endcase
  end

  // Leaving PAYLOAD for DONE is delayed a cycle so the last write lands before the CPU is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      partial  <= '0;
      fin_pend <= 1'b0;
      we       <= 1'b0;
      waddr    <= BASE;
      wdata    <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      we       <= 1'b0;
      fin_pend <= 1'b0;
      if (take) begin
        case (state)
          LEN_LO: len[7:0]  <= rx_data;
          LEN_HI: len[15:8] <= rx_data;
          PAYLOAD: begin
`ifdef LOADER_CSUM_EN
            csum     <= csum ^ rx_data;
`endif
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: partial[7:0]   <= rx_data;
              2'd1: partial[15:8]  <= rx_data;
              2'd2: partial[23:16] <= rx_data;
              default: begin
                we       <= 1'b1;
                wdata    <= {rx_data, partial};
                waddr    <= BASE + ADDR_WIDTH'({word_cnt, 2'b00});
                word_cnt <= word_cnt + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
      if (fin_pend) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (next_state != state) begin
        if (next_state == ERROR)
          error <= 1'b1;
        else if (next_state == DONE) begin
          if (state == PAYLOAD)
            fin_pend <= 1'b1;
          else begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: per-cycle vector table plus directed multi-cycle sequences.
// Checksum-specific sequences compile in when LOADER_CSUM_EN is defined.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        hold;
    logic        done;
    logic        err;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] pay[16];

  instr_loader dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      cap_addr.push_back(waddr);
      cap_data.push_back(wdata);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cap_a(input int i);
    if (i < cap_addr.size()) return cap_addr[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] cap_d(input int i);
    if (i < cap_data.size()) return cap_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic finish_stream(input logic [7:0] x);
`ifdef LOADER_CSUM_EN
    apply_stimulus(x);
`else
    $display("[TB] stream end, payload xor %h not sent", x);
`endif
  endtask

  initial begin
    int         wb;
    int         idx;
    logic       acc;
    logic [7:0] x;
    logic [31:0] w;

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    for (int j = 0; j < 16; j++) pay[j] = 8'((j * 37 + 5) & 255);

    //            rst   vld   data   rdy   we    waddr        wdata          hold  done  err
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, BASE,        32'h0,         1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, BASE,        32'h0,         1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, BASE,        32'h0,         1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'h13, 1'b1, 1'b0, BASE,        32'h0,         1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, BASE,        32'h0,         1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, BASE,        32'h0,         1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, BASE,        32'h0000_0013, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'h93, 1'b1, 1'b0, BASE,        32'h0000_0013, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h05, 1'b1, 1'b0, BASE,        32'h0000_0013, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h50, 1'b1, 1'b0, BASE,        32'h0000_0013, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, BASE + 32'd4, 32'h0050_0593, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, BASE + 32'd4, 32'h0050_0593, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, BASE + 32'd4, 32'h0050_0593, 1'b0, 1'b1, 1'b0};

`ifndef LOADER_CSUM_EN
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      rx_valid = vecs[i].valid;
      rx_data  = vecs[i].data;
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d rx_ready", i), 32'(rx_ready), 32'(vecs[i].ready));
      check_output($sformatf("vec%0d we", i),       32'(we),       32'(vecs[i].we));
      check_output($sformatf("vec%0d waddr", i),    waddr,         vecs[i].waddr);
      check_output($sformatf("vec%0d wdata", i),    wdata,         vecs[i].wdata);
      check_output($sformatf("vec%0d cpu_hold", i), 32'(cpu_hold), 32'(vecs[i].hold));
      check_output($sformatf("vec%0d done", i),     32'(done),     32'(vecs[i].done));
      check_output($sformatf("vec%0d error", i),    32'(error),    32'(vecs[i].err));
    end
    rx_valid = 1'b0;

    // Empty image: header 00 00 finishes immediately with no write.
    do_reset();
    wb = cap_addr.size();
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    check_output("n0 done", 32'(done), 32'd1);
    check_output("n0 cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("n0 error", 32'(error), 32'd0);
    idle(3);
    check_output("n0 writes", 32'(cap_addr.size() - wb), 32'd0);
`else
    do_reset();
    wb = cap_addr.size();
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    check_output("n0 csum done", 32'(done), 32'd1);
    check_output("n0 csum cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("n0 csum writes", 32'(cap_addr.size() - wb), 32'd0);

    // Single word 0x08040201; checksum 0F matches, 0E does not.
    do_reset();
    wb = cap_addr.size();
    apply_stimulus(8'h01); apply_stimulus(8'h00);
    apply_stimulus(8'h01); apply_stimulus(8'h02); apply_stimulus(8'h04); apply_stimulus(8'h08);
    apply_stimulus(8'h0F);
    check_output("csum ok done", 32'(done), 32'd1);
    check_output("csum ok error", 32'(error), 32'd0);
    check_output("csum ok cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("csum ok writes", 32'(cap_addr.size() - wb), 32'd1);
    check_output("csum ok waddr", cap_a(wb), BASE);
    check_output("csum ok wdata", cap_d(wb), 32'h0804_0201);

    do_reset();
    wb = cap_addr.size();
    apply_stimulus(8'h01); apply_stimulus(8'h00);
    apply_stimulus(8'h01); apply_stimulus(8'h02); apply_stimulus(8'h04); apply_stimulus(8'h08);
    apply_stimulus(8'h0E);
    check_output("csum bad error", 32'(error), 32'd1);
    check_output("csum bad done", 32'(done), 32'd0);
    check_output("csum bad cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("csum bad rx_ready", 32'(rx_ready), 32'd0);
    check_output("csum bad writes", 32'(cap_addr.size() - wb), 32'd1);
    check_output("csum bad wdata", cap_d(wb), 32'h0804_0201);
`endif

    // Oversize header 1025 = 0x0401.
    do_reset();
    wb = cap_addr.size();
    apply_stimulus(8'h01);
    apply_stimulus(8'h04);
    check_output("big error", 32'(error), 32'd1);
    check_output("big rx_ready", 32'(rx_ready), 32'd0);
    check_output("big cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("big done", 32'(done), 32'd0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    idle(5);
    rx_valid = 1'b0;
    check_output("big error sticky", 32'(error), 32'd1);
    check_output("big writes", 32'(cap_addr.size() - wb), 32'd0);

    // Reset two bytes into word 1 discards the partial word.
    do_reset();
    wb = cap_addr.size();
    apply_stimulus(8'h02); apply_stimulus(8'h00);
    apply_stimulus(8'h11); apply_stimulus(8'h22); apply_stimulus(8'h33); apply_stimulus(8'h44);
    apply_stimulus(8'h55); apply_stimulus(8'h66);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    @(posedge clk);
    #1;
    check_output("mid rst rx_ready", 32'(rx_ready), 32'd0);
    check_output("mid rst waddr", waddr, BASE);
    check_output("mid rst cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    apply_stimulus(8'h01); apply_stimulus(8'h00);
    apply_stimulus(8'hAA); apply_stimulus(8'hBB); apply_stimulus(8'hCC); apply_stimulus(8'hDD);
    finish_stream(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
    idle(2);
    check_output("mid rst done", 32'(done), 32'd1);
    check_output("mid rst writes", 32'(cap_addr.size() - wb), 32'd2);
    check_output("mid rst w0 addr", cap_a(wb), BASE);
    check_output("mid rst w0 data", cap_d(wb), 32'h4433_2211);
    check_output("mid rst w1 addr", cap_a(wb + 1), BASE);
    check_output("mid rst w1 data", cap_d(wb + 1), 32'hDDCC_BBAA);

    // Four-word image, first gap-free then with random valid gaps.
    x = 8'h00;
    for (int j = 0; j < 16; j++) x = x ^ pay[j];
    for (int run = 0; run < 2; run++) begin
      do_reset();
      wb = cap_addr.size();
      apply_stimulus(8'h04);
      apply_stimulus(8'h00);
      idx = 0;
      for (int c = 0; c < 400 && idx < 16; c++) begin
        @(negedge clk);
        rx_valid = (run == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rx_data  = pay[idx];
        acc      = rx_valid && rx_ready;
        @(posedge clk);
        #1;
        if (acc) idx++;
      end
      rx_valid = 1'b0;
      check_output($sformatf("run%0d bytes sent", run), 32'(idx), 32'd16);
      finish_stream(x);
      idle(2);
      check_output($sformatf("run%0d done", run), 32'(done), 32'd1);
      check_output($sformatf("run%0d we count", run), 32'(cap_addr.size() - wb), 32'd4);
      for (int i = 0; i < 4; i++) begin
        w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
        check_output($sformatf("run%0d w%0d addr", run, i), cap_a(wb + i), BASE + 32'(4 * i));
        check_output($sformatf("run%0d w%0d data", run, i), cap_d(wb + i), w);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
